// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency-word sweep controller driving a DDS
//
// Purpose: steps a DDS frequency word from f_start to f_stop in increments of
// step, holding each word for dwell cycles. Supports up-once, up-repeat
// (sawtooth) and triangle sweeps with hold/pause and abort.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, stop, hold   sweep control (stop has priority)
//   mode                00 up-once, 01 up-repeat, 10 triangle, 11 invalid
//   f_start, f_stop     sweep bounds (frequency words)
//   step                frequency-word increment
//   dwell               cycles per word (0 behaves as 1)
//   frq_w               registered frequency word to the DDS
//   freq_upd            pulse in the cycle frq_w takes a newly loaded value
//   busy                high while running or paused
//   done                pulse when an up-once sweep completes
//   err                 pulse when a start is rejected for a bad config
module dds_sweep_ctrl #(
    parameter int FW_W    = 6,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic [1:0]         mode,
    input  logic [FW_W-1:0]    f_start,
    input  logic [FW_W-1:0]    f_stop,
    input  logic [FW_W-1:0]    step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FW_W-1:0]    frq_w,
    output logic               freq_upd,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]         MODE_ONCE   = 2'b00;
    localparam logic [1:0]         MODE_REPEAT = 2'b01;
    localparam logic [1:0]         MODE_BAD    = 2'b11;
    localparam logic [DWELL_W-1:0] CNT_ONE     = DWELL_W'(1);

    state_t              state_q, state_d;
    logic [FW_W-1:0]     frq_q, frq_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic                dir_down_q, dir_down_d;
    logic [1:0]          mode_q, mode_d;
    logic [FW_W-1:0]     fs_q, fs_d;
    logic [FW_W-1:0]     fe_q, fe_d;
    logic [FW_W-1:0]     step_q, step_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                upd_q, upd_d;
    logic                err_q, err_d;

    logic                cfg_ok;
    logic [DWELL_W-1:0]  dwell_eff;
    logic [FW_W:0]       up_sum;
    logic signed [FW_W+1:0] down_diff;
    logic [FW_W-1:0]     up_nxt;
    logic [FW_W-1:0]     down_nxt;
    logic                expire;

    assign cfg_ok    = (f_start <= f_stop) && (step != '0) && (mode != MODE_BAD);
    assign dwell_eff = (dwell == '0) ? CNT_ONE : dwell;

    // Up step saturates at f_stop; one extra bit keeps the sum from wrapping.
    assign up_sum = {1'b0, frq_q} + {1'b0, step_q};
    assign up_nxt = (up_sum > {1'b0, fe_q}) ? fe_q : up_sum[FW_W-1:0];

    // Down step saturates at f_start; signed difference catches underflow.
    assign down_diff = $signed({2'b00, frq_q}) - $signed({2'b00, step_q});
    assign down_nxt  = (down_diff < $signed({2'b00, fs_q})) ? fs_q : down_diff[FW_W-1:0];

    always_comb begin
        state_d    = state_q;
        frq_d      = frq_q;
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        mode_d     = mode_q;
        fs_d       = fs_q;
        fe_d       = fe_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        upd_d      = 1'b0;
        err_d      = 1'b0;
        expire     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!stop && start) begin
                    if (cfg_ok) begin
                        mode_d     = mode;
                        fs_d       = f_start;
                        fe_d       = f_stop;
                        step_d     = step;
                        dwell_d    = dwell_eff;
                        frq_d      = f_start;
                        upd_d      = 1'b1;
                        dir_down_d = 1'b0;
                        cnt_d      = dwell_eff;
                        state_d    = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = hold ? S_PAUSE : S_RUN;
                    // An expiring word still steps when hold arrives with it.
                    if (cnt_q == CNT_ONE) begin
                        expire = 1'b1;
                    end else if (!hold) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    // The release cycle counts as a run cycle, so the word is
                    // held exactly dwell plus the number of hold cycles.
                    state_d = S_RUN;
                    if (cnt_q == CNT_ONE) begin
                        expire = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (expire) begin
            cnt_d = dwell_q;
            upd_d = 1'b1;
            if (!dir_down_q) begin
                if (frq_q == fe_q) begin
                    case (mode_q)
                        MODE_ONCE: begin
                            state_d = S_DONE;
                            upd_d   = 1'b0;
                        end
                        MODE_REPEAT: begin
                            frq_d = fs_q;
                        end
                        default: begin
                            dir_down_d = 1'b1;
                            frq_d      = down_nxt;
                        end
                    endcase
                end else begin
                    frq_d = up_nxt;
                end
            end else begin
                if (frq_q == fs_q) begin
                    dir_down_d = 1'b0;
                    frq_d      = up_nxt;
                end else begin
                    frq_d = down_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            frq_q      <= '0;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            mode_q     <= '0;
            fs_q       <= '0;
            fe_q       <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frq_q      <= frq_d;
            cnt_q      <= cnt_d;
            dir_down_q <= dir_down_d;
            mode_q     <= mode_d;
            fs_q       <= fs_d;
            fe_q       <= fe_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
        end
    end

    assign frq_w    = frq_q;
    assign freq_upd = upd_q;
    assign busy     = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;

endmodule
